// File: rtl/uart_stim_tx.sv
// FIFO-buffered UART transmitter that feeds scripted bytes into a serial RX pin.
// Frames are 8 data bits, LSB first, with 1 or 2 stop bits; the line idles high.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (line low) for one bit time
// DATA  | shifting out data bits 0..7, one bit time each
// STOP  | stop bit(s) high; pops the next byte straight into START if one is queued
module uart_stim_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          rst_pad_i,
  input  logic                          wr_valid_i,
  input  logic [7:0]                    wr_data_i,
  output logic                          wr_ready_o,
  output logic                          uart_tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o
);

  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int LW        = AW + 1;
  localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
  localparam int CW        = $clog2(STOP_CLKS);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level, level_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          full, push, pop, bit_done, stop_done, idle_nxt;

  always_comb begin
    full      = (level == LW'(FIFO_DEPTH));
    push      = wr_valid_i && !full;
    bit_done  = (cnt == CW'(CLKS_PER_BIT - 1));
    stop_done = (cnt == CW'(STOP_CLKS - 1));
    pop       = (level != '0) && ((state == IDLE) || ((state == STOP) && stop_done));
    level_nxt = level + LW'(push) - LW'(pop);
    idle_nxt  = ((state == IDLE) && !pop) || ((state == STOP) && stop_done && !pop);
  end

  assign wr_ready_o   = !full;
  assign fifo_level_o = level;

  // Storage needs no reset: level and pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data_i;
  end

  always_ff @(posedge clk or posedge rst_pad_i) begin
    if (rst_pad_i) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow_o <= 1'b0;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      uart_tx_o  <= 1'b1;
      busy_o     <= 1'b0;
    end else begin
      level  <= level_nxt;
      busy_o <= !idle_nxt || (level_nxt != '0);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (wr_valid_i && full) overflow_o <= 1'b1;

      case (state)
        IDLE: begin
          if (pop) begin
            shift     <= mem[rd_ptr];
            cnt       <= '0;
            uart_tx_o <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (bit_done) begin
            cnt       <= '0;
            bit_idx   <= '0;
            uart_tx_o <= shift[0];
            state     <= DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              uart_tx_o <= 1'b1;
              state     <= STOP;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              uart_tx_o <= shift[bit_idx + 3'd1];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (stop_done) begin
            cnt <= '0;
            // Chain straight into the next start bit so queued bytes go out gap-free.
            if (pop) begin
              shift     <= mem[rd_ptr];
              uart_tx_o <= 1'b0;
              state     <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          uart_tx_o <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
